// File: rtl/word_link_pkg.sv
// Shared definitions for the bootloader word link (transmitter and receiver sides).
// Holds the link FSM encoding, default timing parameters and the address width.
package word_link_pkg;

    localparam int DEFAULT_WORD_WIDTH = 32;
    localparam int DEFAULT_CLK_DIV    = 4;
    localparam int DEFAULT_GAP_CYCLES = 8;
    localparam int ADDR_WIDTH         = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_GAP
    } link_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/link_phase_timer.sv
// Loadable down-counter timing the LOW, HIGH and GAP phases of the link.
// Loading value V makes expired assert V cycles later, so a phase of N cycles loads N-1.
module link_phase_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/word_transmitter.sv
// Serial word transmitter: double-buffered 32-bit words shifted out MSB-first
// on a tx_clock/tx_data pair, gated by the receiver's ready line.
module word_transmitter
    import word_link_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  peer_ready,
    output logic                  tx_clock,
    output logic                  tx_data,
    output logic                  busy,
    output logic                  word_done,
    output logic                  abort,
    output logic [ADDR_WIDTH-1:0] words_sent
);

    localparam int TIMER_W   = $clog2(max_int(CLK_DIV, GAP_CYCLES) + 1);
    localparam int BIT_CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    localparam logic [TIMER_W-1:0]   PHASE_LOAD = TIMER_W'(CLK_DIV - 1);
    localparam logic [TIMER_W-1:0]   GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT   = BIT_CNT_W'(WORD_WIDTH - 1);

    link_state_e             state_q,      state_d;
    logic [WORD_WIDTH-1:0]   hold_q,       hold_d;
    logic                    hold_full_q,  hold_full_d;
    logic [WORD_WIDTH-1:0]   shift_q,      shift_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q,    bit_cnt_d;
    logic                    tx_clock_q,   tx_clock_d;
    logic                    tx_data_q,    tx_data_d;
    logic                    in_ready_q,   in_ready_d;
    logic                    busy_q,       busy_d;
    logic                    word_done_q,  word_done_d;
    logic                    abort_q,      abort_d;
    logic [ADDR_WIDTH-1:0]   words_sent_q, words_sent_d;

    logic                    accept;
    logic                    load_word;
    logic [WORD_WIDTH-1:0]   shifted;
    logic                    timer_load;
    logic [TIMER_W-1:0]      timer_value;
    logic                    timer_expired;

    link_phase_timer #(
        .WIDTH (TIMER_W)
    ) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .expired    (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        tx_clock_d   = tx_clock_q;
        tx_data_d    = tx_data_q;
        word_done_d  = 1'b0;
        abort_d      = 1'b0;
        words_sent_d = words_sent_q;
        timer_load   = 1'b0;
        timer_value  = PHASE_LOAD;
        load_word    = 1'b0;
        accept       = in_valid && !hold_full_q;
        shifted      = shift_q << 1;

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q && peer_ready) begin
                    load_word = 1'b1;
                end
            end
            ST_LOW, ST_HIGH: begin
                if (!peer_ready) begin
                    // Receiver went away mid-word: drop the word, keep whatever is queued.
                    state_d    = ST_IDLE;
                    tx_clock_d = 1'b0;
                    tx_data_d  = 1'b0;
                    shift_d    = '0;
                    abort_d    = 1'b1;
                end else if (timer_expired && state_q == ST_LOW) begin
                    state_d    = ST_HIGH;
                    tx_clock_d = 1'b1;
                    timer_load = 1'b1;
                end else if (timer_expired && bit_cnt_q != '0) begin
                    state_d    = ST_LOW;
                    tx_clock_d = 1'b0;
                    tx_data_d  = shifted[WORD_WIDTH-1];
                    shift_d    = shifted;
                    bit_cnt_d  = bit_cnt_q - BIT_CNT_W'(1);
                    timer_load = 1'b1;
                end else if (timer_expired) begin
                    state_d      = ST_GAP;
                    tx_clock_d   = 1'b0;
                    tx_data_d    = 1'b0;
                    word_done_d  = 1'b1;
                    words_sent_d = words_sent_q + ADDR_WIDTH'(1);
                    timer_load   = 1'b1;
                    timer_value  = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (timer_expired) begin
                    if (hold_full_q && peer_ready) begin
                        load_word = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Loading drives tx_data to the new MSB on the LOW entry edge.
        if (load_word) begin
            state_d     = ST_LOW;
            shift_d     = hold_q;
            bit_cnt_d   = LAST_BIT;
            tx_clock_d  = 1'b0;
            tx_data_d   = hold_q[WORD_WIDTH-1];
            timer_load  = 1'b1;
            timer_value = PHASE_LOAD;
        end

        hold_full_d = (hold_full_q && !load_word) || accept;
        if (accept) begin
            hold_d = in_data;
        end else if (load_word) begin
            hold_d = '0;
        end else begin
            hold_d = hold_q;
        end

        in_ready_d = !hold_full_d;
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            tx_clock_q   <= 1'b0;
            tx_data_q    <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            word_done_q  <= 1'b0;
            abort_q      <= 1'b0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_clock_q   <= tx_clock_d;
            tx_data_q    <= tx_data_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            word_done_q  <= word_done_d;
            abort_q      <= abort_d;
            words_sent_q <= words_sent_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign tx_clock   = tx_clock_q;
    assign tx_data    = tx_data_q;
    assign busy       = busy_q;
    assign word_done  = word_done_q;
    assign abort      = abort_q;
    assign words_sent = words_sent_q;

endmodule
